// File: rtl/fib_stream_gen.sv
// Streaming Fibonacci generator: one request N in, terms F(0)..F(N) out, saturating at DATA_W bits.
// Latency: first beat valid the cycle after request accept; one beat per cycle; one idle bubble between requests.
// Backpressure: while out_valid && !out_ready all out_* hold stable and no state advances; req_ready only in IDLE.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req_valid/req_ready/req_n     request port, N = last term index to emit (inclusive)
//   out_valid/out_ready           output beat handshake
//   out_data/out_idx              F(idx) (saturated) and its index
//   out_last                      beat carries F(N)
//   out_ovf                       sticky: the emitted term (this or an earlier beat) was saturated
//   perf_req_cnt/perf_stall_cnt   only when FIB_PERF_CNT_EN is defined: completed requests, stalled cycles
module fib_stream_gen #(
    parameter int DATA_W = 32,
    parameter int N_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [N_W-1:0]    req_n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [N_W-1:0]    out_idx,
    output logic              out_last,
    output logic              out_ovf
`ifdef FIB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   a, b;        // a = current term, b = next term
    logic [N_W-1:0]      idx, n;
    logic                ovf;         // saturation has reached an emitted term
    logic                b_sat;       // b (the not-yet-emitted term) has been saturated

    logic [DATA_W:0]     sum;
    logic                carry;
    logic [DATA_W-1:0]   b_next;
    logic                is_last;
    logic                req_fire;
    logic                out_fire;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign carry   = sum[DATA_W];
    assign b_next  = carry ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    assign is_last = (idx == n);

    assign req_fire = req_valid && req_ready;
    assign out_fire = out_valid && out_ready;

    // Outputs are driven to zero outside RUN so that reset and the inter-request
    // bubble both present the reset values on every out_* port.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_ovf   = 1'b0;
        case (state)
            IDLE: begin
                // Held low during reset so a request presented then is never seen as accepted.
                req_ready = !rst;
                if (req_valid && !rst) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                out_data  = a;
                out_idx   = idx;
                out_last  = is_last;
                out_ovf   = ovf;
                if (out_ready && is_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            idx   <= '0;
            n     <= '0;
            ovf   <= 1'b0;
            b_sat <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                a     <= '0;
                b     <= DATA_W'(1);
                idx   <= '0;
                n     <= req_n;
                ovf   <= 1'b0;
                b_sat <= 1'b0;
            end else if (out_fire && !is_last) begin
                a     <= b;
                b     <= b_next;
                idx   <= idx + 1'b1;
                // Overflow is flagged on the beat whose data is the saturated value,
                // so the flag follows the term from b into a.
                ovf   <= ovf | b_sat;
                b_sat <= b_sat | carry;
            end
        end
    end

`ifdef FIB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_req_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (out_fire && is_last) begin
                perf_req_cnt <= perf_req_cnt + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
